// File: rtl/strassen_pkg.sv
// rtl/strassen_pkg.sv - shared defaults, feeder FSM encoding and quadrant row address helper
package strassen_pkg;

    localparam int DEF_MAT_SIZE      = 256;
    localparam int DEF_ELEM_BITWIDTH = 8;
    localparam int DEF_ROW_WIDTH     = DEF_MAT_SIZE * DEF_ELEM_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } feed_state_e;

    // Row number for quadrant offset ofs within group grp: {ofs, grp}.
    function automatic int unsigned quad_row_addr(input int unsigned grp,
                                                  input int unsigned ofs,
                                                  input int unsigned mat_size);
        return grp + ofs * (mat_size / 4);
    endfunction

endpackage

// File: rtl/row_buffer_1r1w.sv
// rtl/row_buffer_1r1w.sv - row RAM with synchronous write and registered read, contents not reset
module row_buffer_1r1w #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/strassen_row_feeder.sv
// rtl/strassen_row_feeder.sv - buffers A/B rows and streams them in group-major quadrant order
module strassen_row_feeder
    import strassen_pkg::*;
#(
    parameter int MAT_SIZE      = DEF_MAT_SIZE,
    parameter int ELEM_BITWIDTH = DEF_ELEM_BITWIDTH,
    parameter int ROW_WIDTH     = MAT_SIZE * ELEM_BITWIDTH,
    parameter int AW            = $clog2(MAT_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [AW-1:0]        wr_addr,
    input  logic [ROW_WIDTH-1:0] wr_data,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic                 row_valid,
    output logic [AW-1:0]        row_index,
    output logic [0:ROW_WIDTH-1] A_out,
    output logic [0:ROW_WIDTH-1] B_out,
    output logic                 last,
    output logic                 done
);

    localparam int GW = (AW > 2) ? AW - 2 : 1;

    feed_state_e          state_q;
    logic [GW-1:0]        grp_q, grp_d;
    logic [1:0]           ofs_q, ofs_d;
    logic                 busy_q, done_q;
    logic                 valid1_q, last1_q;
    logic [AW-1:0]        idx1_q;
    logic                 row_valid_q, last_q;
    logic [AW-1:0]        row_index_q;
    logic [0:ROW_WIDTH-1] a_out_q, b_out_q;

    logic                 adv, issue, final_rd, wr_a, wr_b;
    logic [AW-1:0]        rd_addr;
    logic [ROW_WIDTH-1:0] a_rdata, b_rdata;

    // The whole two-stage pipeline (RAM read register, output register) moves only on adv.
    always_comb begin
        adv      = (state_q != ST_IDLE) && !stall;
        issue    = adv && ((state_q == ST_FETCH) || (state_q == ST_STREAM));
        rd_addr  = AW'(quad_row_addr(32'(grp_q), 32'(ofs_q), MAT_SIZE));
        final_rd = (ofs_q == 2'd3) && (32'(grp_q) == 32'(MAT_SIZE / 4 - 1));
        wr_a     = wr_en && !wr_sel && (state_q == ST_IDLE);
        wr_b     = wr_en &&  wr_sel && (state_q == ST_IDLE);
        ofs_d    = ofs_q + 2'd1;
        grp_d    = (ofs_q == 2'd3) ? grp_q + 1'b1 : grp_q;
        if (final_rd) begin
            ofs_d = '0;
            grp_d = '0;
        end
    end

    row_buffer_1r1w #(.DEPTH(MAT_SIZE), .WIDTH(ROW_WIDTH), .AW(AW)) u_buf_a (
        .clk     (clk),
        .we_i    (wr_a),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (issue),
        .raddr_i (rd_addr),
        .rdata_o (a_rdata)
    );

    row_buffer_1r1w #(.DEPTH(MAT_SIZE), .WIDTH(ROW_WIDTH), .AW(AW)) u_buf_b (
        .clk     (clk),
        .we_i    (wr_b),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (issue),
        .raddr_i (rd_addr),
        .rdata_o (b_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grp_q       <= '0;
            ofs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid1_q    <= 1'b0;
            last1_q     <= 1'b0;
            idx1_q      <= '0;
            row_valid_q <= 1'b0;
            last_q      <= 1'b0;
            row_index_q <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!stall) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (!stall && final_rd) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // busy stays high through the done cycle and drops in IDLE.
                    if (!stall && last_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (issue) begin
                ofs_q  <= ofs_d;
                grp_q  <= grp_d;
                idx1_q <= rd_addr;
            end
            if (adv) begin
                valid1_q    <= issue;
                last1_q     <= issue && final_rd;
                row_valid_q <= valid1_q;
                last_q      <= last1_q;
                if (valid1_q) begin
                    row_index_q <= idx1_q;
                    a_out_q     <= a_rdata;
                    b_out_q     <= b_rdata;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign row_valid = row_valid_q;
    assign last      = last_q;
    assign row_index = row_index_q;
    assign A_out     = a_out_q;
    assign B_out     = b_out_q;

endmodule

// File: tb/tb_strassen_row_feeder.sv
// tb/tb_strassen_row_feeder.sv - randomized self-checking bench for strassen_row_feeder
module tb_strassen_row_feeder;

    localparam int N  = 256;
    localparam int EW = 8;
    localparam int RW = N * EW;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, stall = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [RW-1:0] wr_data = '0;
    logic          busy, row_valid, last, done;
    logic [AW-1:0] row_index;
    logic [0:RW-1] A_out, B_out;

    logic [RW-1:0] a_mem [N];
    logic [RW-1:0] b_mem [N];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    strassen_row_feeder #(.MAT_SIZE(N), .ELEM_BITWIDTH(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .row_valid (row_valid),
        .row_index (row_index),
        .A_out     (A_out),
        .B_out     (B_out),
        .last      (last),
        .done      (done)
    );

    // k-th emitted row: four quadrant offsets per group, groups in ascending order.
    function automatic int exp_row(input int k);
        return (k % 4) * (N / 4) + k / 4;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic write_row(input logic sel, input int addr, input logic [RW-1:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        logic [RW-1:0] ga, gb;
        ga = A_out; gb = B_out;
        checks++;
        if ({busy, row_valid, last, done} !== 4'b0) begin
            failures++;
            $display("FAIL %s flags got busy/valid/last/done=%b want 0000", tag, {busy, row_valid, last, done});
        end
        checks++;
        if (row_index !== '0 || ga !== '0 || gb !== '0) begin
            failures++;
            $display("FAIL %s data got idx=%0d a_lo=%h b_lo=%h want zeros", tag, row_index, ga[31:0], gb[31:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_matrices();
        logic [RW-1:0] p;
        for (int r = 0; r < N; r++) begin
            p = rand_row();
            a_mem[r] = p;
            b_mem[r] = ~p;
            write_row(1'b0, r, a_mem[r]);
            write_row(1'b1, r, b_mem[r]);
        end
    endtask

    // Streams once and checks every presented row against the model.
    task automatic run_stream(input string tag, input int stall_at, input int stall_len,
                              input int abort_row, input int poke_at, input bit pre_write);
        int k, done_cyc, first_valid, stall_left;
        bit stall_used, aborted;
        logic [RW-1:0] ga, gb, nw;
        k = 0; done_cyc = -1; first_valid = -1; stall_left = 0;
        stall_used = 1'b0; aborted = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_idle got %b want 0", tag, busy);
        end
        if (pre_write) begin
            nw = rand_row();
            b_mem[N-1] = nw;
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = AW'(N - 1); wr_data = nw;
            @(negedge clk);
            wr_en = 1'b0;
        end
        start = 1'b1;
        for (int cyc = 0; cyc < N + stall_len + 20; cyc++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (cyc == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_after_start got %b want 1", tag, busy);
                end
            end
            if (row_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                ga = A_out; gb = B_out;
                checks++;
                if (k >= N || row_index !== AW'(exp_row(k)) || ga !== a_mem[exp_row(k)] ||
                    gb !== b_mem[exp_row(k)] || last !== (k == N - 1)) begin
                    failures++;
                    $display("FAIL %s row k=%0d got idx=%0d last=%b a_lo=%h b_lo=%h want idx=%0d last=%b a_lo=%h b_lo=%h",
                             tag, k, row_index, last, ga[31:0], gb[31:0], exp_row(k % N), (k == N - 1),
                             a_mem[exp_row(k % N)][31:0], b_mem[exp_row(k % N)][31:0]);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (busy !== 1'b1 || row_valid !== 1'b0 || last !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_cycle got busy=%b valid=%b last=%b want 1 0 0", tag, busy, row_valid, last);
                end
                break;
            end
            if (row_valid === 1'b1 && exp_row(k) == abort_row) begin
                #2 rst = 1'b1;
                #1 check_zero_outputs({tag, "_async"});
                @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check_zero_outputs({tag, "_after"});
                end
                aborted = 1'b1;
                break;
            end
            if (row_valid === 1'b1 && k == poke_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = '1;
                start = 1'b1;
            end
            if (row_valid === 1'b1 && k == stall_at && !stall_used) begin
                stall_left = stall_len;
                stall_used = 1'b1;
            end
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = 1'b0;
                if (row_valid === 1'b1) k++;
            end
        end
        stall = 1'b0;
        if (!aborted) begin
            checks++;
            if (done_cyc != N + 2 + stall_len) begin
                failures++;
                $display("FAIL %s done_latency got %0d want %0d", tag, done_cyc, N + 2 + stall_len);
            end
            checks++;
            if (first_valid != 2 || k != N) begin
                failures++;
                $display("FAIL %s stream_shape got first=%0d rows=%0d want first=2 rows=%0d", tag, first_valid, k, N);
            end
            if (poke_at >= 0) begin
                repeat (8) begin
                    @(negedge clk);
                    checks++;
                    if (busy !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0) begin
                        failures++;
                        $display("FAIL %s no_restream got busy=%b valid=%b done=%b want 0 0 0", tag, busy, row_valid, done);
                    end
                end
            end
        end
    endtask

    task automatic test_order();
        run_stream("order", -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_stall();
        run_stream("stall10", 9, 5, -1, -1, 1'b0);
        run_stream("stall_rand", $urandom_range(0, N - 2), $urandom_range(1, 4), -1, -1, 1'b0);
        run_stream("stall_last", N - 1, 3, -1, -1, 1'b0);
    endtask

    task automatic test_busy_protect();
        run_stream("busy_poke", -1, 0, -1, 20, 1'b0);
        run_stream("busy_restream", -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_mid_reset();
        run_stream("midrst", -1, 0, 100, -1, 1'b0);
        run_stream("midrst_restream", -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b_first", -1, 0, -1, -1, 1'b0);
        run_stream("b2b_second", -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_write_then_start();
        run_stream("write_then_start", -1, 0, -1, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        load_matrices();
        test_order();
        test_stall();
        test_busy_protect();
        test_mid_reset();
        test_back_to_back();
        test_write_then_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strassen_row_feeder.md
# strassen_row_feeder

Upstream input stage for `strassen_matrix_mult_top`. It buffers all `MAT_SIZE` rows of matrix A and matrix B, written by a host port. On `start` it streams one A row and one B row per cycle. Rows go out in the interleaved quadrant order the multiplier consumes: group-major, four quadrant offsets per group. It replaces the file-driven row sequencing used in simulation so the multiplier can be fed from on-chip storage.

## Interface
- `MAT_SIZE`, 256: matrix dimension; rows per matrix. Must be a power of two and ≥ 4.
- `ELEM_BITWIDTH`, 8: element width.
- `ROW_WIDTH`, `MAT_SIZE*ELEM_BITWIDTH`: row width in bits.
- `AW`, `$clog2(MAT_SIZE)`: row address width.

- `clk`  in  1  single clock. Every register updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  host row write strobe.
- `wr_sel`  in  1  0 = write to A buffer, 1 = write to B buffer.
- `wr_addr`  in  AW  row number being written.
- `wr_data`  in  ROW_WIDTH  row contents, same bit order as `A_out`.
- `start`  in  1  single-cycle request to stream the full matrix pair.
- `stall`  in  1  downstream hold. While high, the row counter and all outputs freeze.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` pulses, inclusive.
- `row_valid`  out  1  `A_out`/`B_out`/`row_index` carry a valid row this cycle.
- `row_index`  out  AW  row number currently presented.
- `A_out`  out  [0:ROW_WIDTH-1]  A row, MSB-first index order, feeds the multiplier `A`.
- `B_out`  out  [0:ROW_WIDTH-1]  B row, feeds the multiplier `B`.
- `last`  out  1  high together with `row_valid` on the final row.
- `done`  out  1  one-cycle pulse, the cycle after the last row.

## Operation
- Two buffers, `MAT_SIZE` x `ROW_WIDTH` each, with synchronous write and registered read. Buffer contents are not reset.
- Writes are accepted only in IDLE. A `wr_en` asserted in any other state is silently dropped.
- FSM states and transitions:
  - IDLE → FETCH on `start`.
  - FETCH → STREAM after one cycle. FETCH issues the first read.
  - STREAM → FLUSH when the final read has been issued and `stall` is low.
  - FLUSH → IDLE after the last row is presented. `done` pulses on entry to IDLE.
- `start` is ignored outside IDLE.
- Issue counter: `grp` (AW-2 bits) and `ofs` (2 bits). Read address = `{ofs, grp}`, which equals grp + ofs*(MAT_SIZE/4).
  - `ofs` increments on each advance. On wrap from 3 → 0, `grp` increments.
  - The final read is at `grp` = MAT_SIZE/4-1, `ofs` = 3, i.e. row MAT_SIZE-1.
- For MAT_SIZE = 256 the emitted sequence is 0, 64, 128, 192, 1, 65, …, 63, 127, 191, 255.
- `row_index` is the registered copy of the read address, aligned with the data.
- `stall` high:
  - counter holds; no read is issued;
  - `A_out`, `B_out`, `row_index`, `row_valid` and `last` hold their values;
  - `done` is deferred until the stall releases.
- After the stream, `A_out`/`B_out` hold the last row. `row_valid` and `last` drop to 0.
- Reset values: `busy`, `row_valid`, `last`, `done` = 0; `row_index` = 0; `A_out`, `B_out` = 0; FSM = IDLE; counters = 0.
- Reset during streaming aborts immediately. No `done` is produced, and a fresh `start` is required afterwards.

## Timing
- `start` sampled high at edge N:
  - `busy` = 1 after N;
  - first `row_valid` after edge N+2;
  - with no stall, `row_valid` is high for exactly MAT_SIZE consecutive cycles;
  - `last` is high on the final of these;
  - `done` pulses the following cycle;
  - `busy` falls after that cycle.
- Stall-free latency from `start` to `done` is MAT_SIZE+2 cycles after N.
- Each `stall` cycle adds exactly one cycle.
- A write in the cycle before `start` is visible in the stream, since the read happens in FETCH or later.

## Structure
- A shared package `strassen_pkg` holds:
  - the `MAT_SIZE`, `ELEM_BITWIDTH` and `ROW_WIDTH` defaults;
  - the FSM state encoding (IDLE, FETCH, STREAM, FLUSH);
  - a `quad_row_addr(grp, ofs)` function.
- One sub-module, `row_buffer_1r1w`: a parameterised single-port-write, registered-read row RAM, instantiated twice (A and B).

## Test plan
- Order check: load A row r = pattern r, B row r = ~pattern r; pulse `start` → `row_index` sequence 0, 64, 128, 192, 1, …, 255. Data matches every row, `last` is only on 255, and `done` comes 258 cycles after `start`.
- Stall: assert `stall` for 5 cycles at the 10th valid row → outputs frozen at row 66 and `done` is delayed by exactly 5 cycles.
- Busy protection: during STREAM, write A row 0 = all-ones and pulse `start` again → the write is dropped (re-stream shows the original row 0) and there is no second stream or extra `done`.
- Mid-stream reset: assert `rst` at row 100 → all outputs go to 0 asynchronously and FSM = IDLE. A new `start` restreams from row 0 with buffer contents intact.
- Back-to-back: issue `start` in the cycle after `done` → the second stream starts with `row_valid` 2 cycles later, in identical order.
- Write-then-start: write B row 255 at edge N-1 and start at edge N → the new value appears on the final row.
